// File: rtl/bcd_xs3_pkg.sv
// rtl/bcd_xs3_pkg.sv - shared types and constants for the BCD-to-Excess-3 sequencer
package bcd_xs3_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] XS3_OFFSET  = 4'd3;
   localparam logic [3:0] BCD_MAX     = 4'd9;
   localparam logic [3:0] XS3_INVALID = 4'h0;

endpackage

// File: rtl/bcd_xs3_digit.sv
// rtl/bcd_xs3_digit.sv - combinational one-digit BCD to Excess-3 converter
module bcd_xs3_digit
   import bcd_xs3_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [3:0] xs3,
   output logic       err
);

   // Non-decimal digits yield a code that can never appear in legal XS3 output.
   always_comb begin
      err = (bcd > BCD_MAX);
      xs3 = err ? XS3_INVALID : (bcd + XS3_OFFSET);
   end

endmodule

// File: rtl/bcd_xs3_seq.sv
// rtl/bcd_xs3_seq.sv - multi-digit BCD to Excess-3 sequencer over one shared digit converter
module bcd_xs3_seq
   import bcd_xs3_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   in_bcd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_xs3,
   output logic [DIGITS-1:0]     out_err_mask,
   output logic                  out_err,
   output logic                  busy
);

   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t              state;
   state_t              state_next;
   logic [IDX_W-1:0]    idx;
   logic [4*DIGITS-1:0] src;
   logic [4*DIGITS-1:0] result;
   logic [DIGITS-1:0]   mask;
   logic [3:0]          digit_in;
   logic [3:0]          digit_xs3;
   logic                digit_err;
   logic                last_digit;

   assign last_digit = (idx == IDX_W'(DIGITS - 1));

   always_comb begin
      digit_in = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == IDX_W'(i)) digit_in = src[4*i +: 4];
      end
   end

   bcd_xs3_digit u_digit (
      .bcd (digit_in),
      .xs3 (digit_xs3),
      .err (digit_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid)   state_next = CONV;
         CONV:    if (last_digit) state_next = DONE;
         DONE:    if (out_ready)  state_next = IDLE;
         default:                 state_next = IDLE;
      endcase
   end

   // Handshake outputs decode state only, so no input reaches an output combinationally.
   always_comb begin
      in_ready  = (state == IDLE);
      busy      = (state == CONV);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src    <= '0;
         idx    <= '0;
         result <= '0;
         mask   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  src    <= in_bcd;
                  idx    <= '0;
                  result <= '0;
                  mask   <= '0;
               end
            end
            CONV: begin
               for (int i = 0; i < DIGITS; i++) begin
                  if (idx == IDX_W'(i)) begin
                     result[4*i +: 4] <= digit_xs3;
                     mask[i]          <= digit_err;
                  end
               end
               idx <= idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign out_xs3      = result;
   assign out_err_mask = mask;
   assign out_err      = |mask;

endmodule

// File: tb/tb_bcd_xs3_seq.sv
// tb/tb_bcd_xs3_seq.sv - directed self-checking bench for bcd_xs3_seq
module tb_bcd_xs3_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_bcd;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_xs3;
   logic [3:0]  out_err_mask;
   logic        out_err;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   bcd_xs3_seq #(.DIGITS(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_bcd       (in_bcd),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_xs3      (out_xs3),
      .out_err_mask (out_err_mask),
      .out_err      (out_err),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_word(input logic [15:0] bcd, input logic [15:0] exp_xs3,
                           input logic [3:0] exp_mask, input string tag);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_bcd   = bcd;
      step();
      in_valid = 1'b0;
      in_bcd   = 16'hxxxx;
      n = 0;
      while (busy && n < 20) begin
         step();
         n++;
      end
      check({tag, " busy_cycles"}, 32'(n), 32'd4);
      check({tag, " out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " out_xs3"}, 32'(out_xs3), 32'(exp_xs3));
      check({tag, " mask"}, 32'(out_err_mask), 32'(exp_mask));
      check({tag, " err"}, 32'(out_err), 32'(|exp_mask));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, " released"}, {30'd0, out_valid, in_ready}, 32'b01);
   endtask

   initial begin
      int          cyc;
      int          npulse;
      int          pulse_cyc [2];
      logic [15:0] pulse_xs3 [2];
      logic        switched;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_bcd    = 16'h0000;
      out_ready = 1'b0;
      #1;
      check("rst in_ready", 32'(in_ready), 32'd1);
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst out_xs3", 32'(out_xs3), 32'd0);
      check("rst mask", 32'(out_err_mask), 32'd0);
      check("rst err", 32'(out_err), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      step();

      run_word(16'h1234, 16'h4567, 4'b0000, "nominal");
      run_word(16'h9870, 16'hCBA3, 4'b0000, "edge");
      run_word(16'h12A9, 16'h450C, 4'b0010, "invalid");

      // Backpressure: result must hold while other words are offered.
      in_valid = 1'b1;
      in_bcd   = 16'h5555;
      step();
      in_valid = 1'b0;
      repeat (4) step();
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         in_bcd   = 16'h1111 * 16'(i);
         step();
         check("bp out_valid", 32'(out_valid), 32'd1);
         check("bp in_ready", 32'(in_ready), 32'd0);
         check("bp out_xs3", 32'(out_xs3), 32'h8888);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("bp transfer", {29'd0, busy, out_valid, in_ready}, 32'b001);
      step();
      check("bp single", {29'd0, busy, out_valid, in_ready}, 32'b001);

      // Reset after two digit writes.
      in_valid = 1'b1;
      in_bcd   = 16'h4321;
      step();
      in_valid = 1'b0;
      repeat (2) step();
      check("rst_mid busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid state", {29'd0, busy, out_valid, in_ready}, 32'b001);
      check("rst_mid out_xs3", 32'(out_xs3), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      run_word(16'h0000, 16'h3333, 4'b0000, "post_rst");

      // Back-to-back with both handshakes tied high.
      in_valid  = 1'b1;
      in_bcd    = 16'h0000;
      out_ready = 1'b1;
      switched  = 1'b0;
      npulse    = 0;
      cyc       = 0;
      while (npulse < 2 && cyc < 40) begin
         step();
         cyc++;
         if (busy && !switched) begin
            in_bcd   = 16'h9999;
            switched = 1'b1;
         end
         if (out_valid) begin
            pulse_cyc[npulse] = cyc;
            pulse_xs3[npulse] = out_xs3;
            npulse++;
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("b2b pulses", 32'(npulse), 32'd2);
      if (npulse == 2) begin
         check("b2b first", 32'(pulse_xs3[0]), 32'h3333);
         check("b2b second", 32'(pulse_xs3[1]), 32'hCCCC);
         check("b2b spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'd6);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
